load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data-bus width; only 32 is supported.
REQ-003 SHALL have port clk_t, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port rst_t, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port d_mem_rd_en_t, input, 1, load request from ctrl.
REQ-006 SHALL have port d_mem_wr_en_t, input, 1, store request from ctrl.
REQ-007 SHALL have port d_mem_size_t, input, 2, access size: 00 word, 10 byte, any other value half.
REQ-008 SHALL have port d_mem_unsigned_t, input, 1, 1 selects zero-extension on load, 0 selects sign-extension.
REQ-009 SHALL have port ALU_Out_t, input, ADDR_WIDTH, byte address.
REQ-010 SHALL have port reg_data_2_t, input, DATA_WIDTH, store data, right-aligned.
REQ-011 SHALL have port d_mem_rd_data_t, output, DATA_WIDTH, extended load result for write-back.
REQ-012 SHALL have port lsu_stall_t, output, 1, freezes the PC and core while an access is pending.
REQ-013 SHALL have port lsu_misalign_t, output, 1, misaligned-access flag.
REQ-014 SHALL have ports mem_req_t (out, 1), mem_we_t (out, 1), mem_addr_t (out, ADDR_WIDTH, word-aligned), mem_be_t (out, 4), mem_wdata_t (out, DATA_WIDTH), mem_ack_t (in, 1) and mem_rdata_t (in, DATA_WIDTH).

Function
REQ-015 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-016 In IDLE with rd_en or wr_en high, the FSM SHALL go to BUSY at the next edge.
REQ-017 In BUSY, the FSM SHALL go to DONE at the first edge that samples mem_ack_t=1.
REQ-018 DONE SHALL last exactly one cycle.
REQ-019 mem_req_t, mem_we_t, mem_addr_t, mem_be_t and mem_wdata_t SHALL be registered; they SHALL be captured on IDLE exit and held constant throughout BUSY.
REQ-020 mem_req_t SHALL be 1 only in BUSY.
REQ-021 lsu_stall_t SHALL be combinational: 1 when (IDLE and (rd_en or wr_en)) or BUSY; 0 in DONE.
REQ-022 The minimum access latency SHALL be 2 cycles: enable at cycle 0, req at cycle 1, ack at cycle 1, DONE with stall=0 at cycle 2.
REQ-023 mem_ack_t outside BUSY SHALL be ignored.
REQ-024 rd_en and wr_en both high SHALL be treated as a store.
REQ-025 Byte lanes: a byte access SHALL set be=0001<<addr[1:0] and replicate wdata[7:0] into all four lanes.
REQ-026 Byte lanes: a half access SHALL set be=0011 or 1100 by addr[1] and replicate wdata[15:0] into both halves.
REQ-027 Byte lanes: a word access SHALL set be=1111.
REQ-028 A load SHALL capture mem_rdata_t at the ack edge, extract the addressed lane, extend it per d_mem_unsigned_t, present it from DONE, and hold it until the next load completes.
REQ-029 A store SHALL leave d_mem_rd_data_t unchanged.
REQ-030 An instruction is consumed in DONE: the same enables seen in the cycle after DONE SHALL be treated as a new access.

Reset
REQ-031 While rst_t=0, the block SHALL force state=IDLE, mem_req_t=0, mem_we_t=0, mem_addr_t=0, mem_be_t=0, mem_wdata_t=0, d_mem_rd_data_t=0 and lsu_misalign_t=0, without waiting for a clock edge.
REQ-032 Reset during BUSY SHALL drop mem_req_t immediately and abandon the outstanding access; any late ack SHALL be ignored.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN SHALL control misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0).
REQ-034 With LSU_MISALIGN_TRAP_EN defined, a misaligned access SHALL issue no mem_req_t, SHALL go IDLE->DONE directly, SHALL register lsu_misalign_t=1 for that DONE cycle, and SHALL leave rd_data unchanged.
REQ-035 With LSU_MISALIGN_TRAP_EN undefined, a misaligned address SHALL be aligned down (low bits cleared to the access size), the access SHALL proceed normally, and lsu_misalign_t SHALL be tied to 0.

Structure
REQ-036 Package lsu_pkg SHALL hold the size encodings (SZ_WORD=00, SZ_BYTE=10), the FSM state type, and the byte-enable constants.
REQ-037 Combinational lane steering and extension SHALL live in sub-module lsu_lane_align, instantiated twice: once for the store path and once for the load path.

Verification
REQ-038 Word load: addr 0x100, size 00, ack on the first req cycle, rdata 0xDEADBEEF -> be=1111, stall high for 2 cycles, d_mem_rd_data_t=0xDEADBEEF in DONE.
REQ-039 Signed byte load: addr 0x103, unsigned=0, rdata 0x80FFFFFF -> be=1000, result 0xFFFFFF80; repeated with unsigned=1 -> 0x00000080.
REQ-040 Half store: addr 0x102, wdata 0x1234ABCD, ack delayed 3 cycles -> req held for 4 cycles, we=1, addr=0x100, be=1100, mem_wdata_t=0xABCDABCD, stall low only in DONE.
REQ-041 Misaligned word load at 0x101 -> with LSU_MISALIGN_TRAP_EN: no req, misalign=1 for one cycle, stall for 1 cycle; without: addr=0x100, be=1111, misalign=0.
REQ-042 Reset asserted in the 2nd BUSY cycle, ack arrives 1 cycle later -> req=0 immediately, state IDLE, rd_data=0, ack ignored; a subsequent load completes normally.
REQ-043 Back-to-back loads with enable held high -> two distinct requests separated by exactly one DONE cycle with req=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state type, byte-enable constants and lane-enable helper
package lsu_pkg;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_WORD ? BE_WORD : size == SZ_BYTE ? BE_BYTE << off : (off[1] ? BE_HALF_HI : BE_HALF_LO);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane steering; store mode replicates right-aligned data, load mode extracts and extends
// Ports: load_i selects load mode; size_i access size; uns_i zero-extend on load; off_i byte offset of the lane;
//        data_i store data or bus read data; data_o replicated store data or extended load result.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        load_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);
    logic [15:0] sh;
    logic [31:0] ld;
    logic [31:0] st;
    assign sh = 16'(data_i >> {off_i, 3'b000});
    always_comb begin
        ld = size_i == SZ_WORD ? data_i
           : size_i == SZ_BYTE ? {{24{~uns_i & sh[7]}}, sh[7:0]}
           : {{16{~uns_i & sh[15]}}, sh[15:0]};
        st = size_i == SZ_WORD ? data_i : size_i == SZ_BYTE ? {4{data_i[7:0]}} : {2{data_i[15:0]}};
        data_o = load_i ? ld : st;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between core control and a req/ack data memory
// Ports: clk_t clock; rst_t async active-low reset; d_mem_rd_en_t/d_mem_wr_en_t access requests (both = store);
//        d_mem_size_t 00 word, 10 byte, else half; d_mem_unsigned_t zero-extend loads; ALU_Out_t byte address;
//        reg_data_2_t store data; d_mem_rd_data_t extended load result; lsu_stall_t core freeze;
//        lsu_misalign_t misalign flag; mem_* registered memory request, mem_ack_t/mem_rdata_t response.
// Config: LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_t,
    input  logic                  rst_t,
    input  logic                  d_mem_rd_en_t,
    input  logic                  d_mem_wr_en_t,
    input  logic [1:0]            d_mem_size_t,
    input  logic                  d_mem_unsigned_t,
    input  logic [ADDR_WIDTH-1:0] ALU_Out_t,
    input  logic [DATA_WIDTH-1:0] reg_data_2_t,
    output logic [DATA_WIDTH-1:0] d_mem_rd_data_t,
    output logic                  lsu_stall_t,
    output logic                  lsu_misalign_t,
    output logic                  mem_req_t,
    output logic                  mem_we_t,
    output logic [ADDR_WIDTH-1:0] mem_addr_t,
    output logic [3:0]            mem_be_t,
    output logic [DATA_WIDTH-1:0] mem_wdata_t,
    input  logic                  mem_ack_t,
    input  logic [DATA_WIDTH-1:0] mem_rdata_t
);
    state_t                state_q, state_d;
    logic                  req_q, req_d, we_q, we_d, uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]            off_q, off_d, size_q, size_d, off_al;
    logic [DATA_WIDTH-1:0] st_data, ld_data;
    logic                  go, half, trap, stall;

    assign go   = d_mem_rd_en_t | d_mem_wr_en_t;
    assign half = d_mem_size_t != SZ_WORD && d_mem_size_t != SZ_BYTE;
    // Offset after aligning down to the access size; untrapped misaligned accesses use this.
    assign off_al = d_mem_size_t == SZ_WORD ? 2'b00 : half ? {ALU_Out_t[1], 1'b0} : ALU_Out_t[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign trap = (half & ALU_Out_t[0]) | (d_mem_size_t == SZ_WORD & |ALU_Out_t[1:0]);
    // High only in the DONE cycle that follows a trapped access.
    always_ff @(posedge clk_t or negedge rst_t)
        if (!rst_t) mis_q <= 1'b0;
        else        mis_q <= state_q == IDLE && go && trap;
    assign lsu_misalign_t = mis_q;
`else
    assign trap = 1'b0;
    assign lsu_misalign_t = 1'b0;
`endif

    lsu_lane_align u_store_align (
        .load_i(1'b0),
        .size_i(d_mem_size_t),
        .uns_i (d_mem_unsigned_t),
        .off_i (off_al),
        .data_i(reg_data_2_t),
        .data_o(st_data)
    );

    lsu_lane_align u_load_align (
        .load_i(1'b1),
        .size_i(size_q),
        .uns_i (uns_q),
        .off_i (off_q),
        .data_i(mem_rdata_t),
        .data_o(ld_data)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: if (go) begin
                stall = 1'b1;
                if (trap) state_d = DONE;
                else begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = d_mem_wr_en_t;
                    addr_d  = {ALU_Out_t[ADDR_WIDTH-1:2], 2'b00};
                    be_d    = be_for(d_mem_size_t, off_al);
                    wdata_d = st_data;
                    off_d   = off_al;
                    size_d  = d_mem_size_t;
                    uns_d   = d_mem_unsigned_t;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack_t) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = ld_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_t or negedge rst_t) begin
        if (!rst_t) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
        end
    end

    assign lsu_stall_t     = stall;
    assign mem_req_t       = req_q;
    assign mem_we_t        = we_q;
    assign mem_addr_t      = addr_q;
    assign mem_be_t        = be_q;
    assign mem_wdata_t     = wdata_q;
    assign d_mem_rd_data_t = rdata_q;
endmodule
